channel_frame_collector: RTL

CHANNEL_FRAME_COLLECTOR -- requirements
Module: channel_frame_collector

---
 rtl/channel_pkg.sv | 14 +
 rtl/sat_counter8.sv | 24 ++
 rtl/channel_frame_collector.sv | 101 ++++++++++
 3 files changed

// File: rtl/channel_pkg.sv
// Shared types and constants for the channel frame collector.
package channel_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_BYTES     = 4;
  localparam int         IDX_W             = $clog2(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    HOLD
  } state_e;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF, with synchronous clear.
module sat_counter8 (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/channel_frame_collector.sv
// Hunts for a sync byte, assembles a 4-byte payload from the channel decoder
// and holds it until the consumer takes it, tracking error statistics.
module channel_frame_collector
  import channel_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_err_detected,
  input  logic                         in_err_corrected,
  input  logic                         frame_ready,
  output logic                         frame_valid,
  output logic [8*PAYLOAD_BYTES-1:0]   frame_data,
  output logic                         frame_corrected,
  output logic [7:0]                   drop_count,
  output logic [7:0]                   corr_count,
  output logic [7:0]                   ovf_count
);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [8*PAYLOAD_BYTES-1:0]   data_q, data_d;
  logic                         fcorr_q, fcorr_d;
  logic                         byte_bad, byte_corr;
  logic                         drop_inc, corr_inc, ovf_inc;

  assign byte_bad  = in_valid & in_err_detected & ~in_err_corrected;
  assign byte_corr = in_valid & in_err_detected &  in_err_corrected;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fcorr_d  = fcorr_q;
    drop_inc = 1'b0;
    corr_inc = 1'b0;
    ovf_inc  = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (in_valid && !byte_bad && (in_data == SYNC_BYTE)) begin
          state_d  = COLLECT;
          idx_d    = '0;
          fcorr_d  = 1'b0;
          corr_inc = byte_corr;
        end
      end

      COLLECT: begin
        if (byte_bad) begin
          state_d  = HUNT;
          drop_inc = 1'b1;
        end else if (in_valid) begin
          // A sync-valued byte here is payload; resync only happens from HUNT.
          data_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + IDX_W'(1);
          if (byte_corr) begin
            fcorr_d  = 1'b1;
            corr_inc = 1'b1;
          end
          if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) state_d = HOLD;
        end
      end

      HOLD: begin
        ovf_inc = in_valid;
        if (frame_ready) state_d = HUNT;
      end

      default: state_d = HUNT;
    endcase
  end

  // NOTE: the payload register is reset because it is a visible output, not a storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      idx_q   <= '0;
      data_q  <= '0;
      fcorr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      fcorr_q <= fcorr_d;
    end
  end

  sat_counter8 u_drop_cnt (.clk(clk), .clr(rst), .inc(drop_inc), .count(drop_count));
  sat_counter8 u_corr_cnt (.clk(clk), .clr(rst), .inc(corr_inc), .count(corr_count));
  sat_counter8 u_ovf_cnt  (.clk(clk), .clr(rst), .inc(ovf_inc),  .count(ovf_count));

  assign frame_valid     = (state_q == HOLD);
  assign frame_data      = data_q;
  assign frame_corrected = fcorr_q;

endmodule
